// File: rtl/residual_block.sv
// residual_block -- integer CNN residual block.
//
// A KERNEL_SIZE x KERNEL_SIZE valid convolution (main path) is added to a
// shortcut (1x1 projection summed over input channels, or identity), passed
// through ReLU, arithmetically shifted right by OUT_SHIFT, narrowed to
// DATA_WIDTH and registered. The datapath is combinational from input_tensor;
// output_tensor is a single register stage (latency 1 clock).
//
// Optional feature macro: RESIDUAL_BLOCK_SAT_EN
//   defined   : narrowed result saturates to [0, 2^(DATA_WIDTH-1)-1]
//   undefined : narrowed result keeps the low DATA_WIDTH bits (wraps)
//
// Ports
//   clk            in   1                   rising-edge clock
//   rst            in   1                   synchronous active-high reset; clears output
//   input_tensor   in   IN_SIZE*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   output_tensor  out  OUT_SIZE*DATA_WIDTH element o at [o*DATA_WIDTH +: DATA_WIDTH]
//
// Element layout is channel-major: idx = c*H*W + y*W + x.

module residual_block #(
  parameter int DATA_WIDTH              = 8,
  parameter int IN_CHANNELS             = 1,
  parameter int OUT_CHANNELS            = 1,
  parameter int IN_HEIGHT               = 4,
  parameter int IN_WIDTH                = 4,
  parameter int KERNEL_SIZE             = 2,
  parameter int STRIDE                  = 1,
  parameter int USE_PROJECTION_SHORTCUT = 1,
  parameter int CONV_WEIGHT             = 1,
  parameter int PROJ_WEIGHT             = 1,
  parameter int OUT_SHIFT               = 0,
  localparam int OUT_HEIGHT = (IN_HEIGHT - KERNEL_SIZE) / STRIDE + 1,
  localparam int OUT_WIDTH  = (IN_WIDTH - KERNEL_SIZE) / STRIDE + 1,
  localparam int IN_SIZE    = IN_CHANNELS * IN_HEIGHT * IN_WIDTH,
  localparam int OUT_SIZE   = OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_SIZE*DATA_WIDTH-1:0]  input_tensor,
  output logic [OUT_SIZE*DATA_WIDTH-1:0] output_tensor
);

  localparam int ACC_W = 2 * DATA_WIDTH + 8;
  localparam int IN_PLANE = IN_HEIGHT * IN_WIDTH;

  localparam logic signed [ACC_W-1:0] CW      = ACC_W'(CONV_WEIGHT);
  localparam logic signed [ACC_W-1:0] PW      = ACC_W'(PROJ_WEIGHT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_WIDTH - 1)) - 1);

  // Identity shortcut adds in[oc] directly, so channel counts must match.
  if (USE_PROJECTION_SHORTCUT == 0 && IN_CHANNELS != OUT_CHANNELS) begin : g_bad_cfg
    $fatal(1, "residual_block: identity shortcut needs IN_CHANNELS == OUT_CHANNELS");
  end

  // Sign-extended input element at flat index idx.
  function automatic logic signed [ACC_W-1:0] elem(
    input logic [IN_SIZE*DATA_WIDTH-1:0] t,
    input int                            idx
  );
    logic signed [DATA_WIDTH-1:0] e;
    e = $signed(t[idx*DATA_WIDTH +: DATA_WIDTH]);
    return ACC_W'(e);
  endfunction

  // ReLU followed by arithmetic right shift.
  function automatic logic signed [ACC_W-1:0] relu_shift(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] r;
    r = (sum < 0) ? '0 : sum;
    return r >>> OUT_SHIFT;
  endfunction

  // Narrow to DATA_WIDTH. Input is never negative (post-ReLU).
  function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] s);
`ifdef RESIDUAL_BLOCK_SAT_EN
    logic signed [ACC_W-1:0] c;
    c = (s > SAT_MAX) ? SAT_MAX : s;
    return DATA_WIDTH'(c);
`else
    return DATA_WIDTH'(s);
`endif
  endfunction

  logic [OUT_SIZE*DATA_WIDTH-1:0] out_p0;
  logic [OUT_SIZE*DATA_WIDTH-1:0] out_p1;
  logic signed [ACC_W-1:0]        conv_acc;
  logic signed [ACC_W-1:0]        sc_acc;

  // Stage p0: combinational conv + shortcut + ReLU/shift/narrow
  always_comb begin
    out_p0   = '0;
    conv_acc = '0;
    sc_acc   = '0;
    for (int oc = 0; oc < OUT_CHANNELS; oc++) begin
      for (int oy = 0; oy < OUT_HEIGHT; oy++) begin
        for (int ox = 0; ox < OUT_WIDTH; ox++) begin
          conv_acc = '0;
          sc_acc   = '0;
          for (int ic = 0; ic < IN_CHANNELS; ic++) begin
            for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
              for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
                conv_acc = conv_acc + CW * elem(input_tensor,
                  ic*IN_PLANE + (oy*STRIDE + ky)*IN_WIDTH + (ox*STRIDE + kx));
              end
            end
            if (USE_PROJECTION_SHORTCUT != 0) begin
              sc_acc = sc_acc + PW * elem(input_tensor,
                ic*IN_PLANE + (oy*STRIDE)*IN_WIDTH + (ox*STRIDE));
            end
          end
          if (USE_PROJECTION_SHORTCUT == 0) begin
            sc_acc = elem(input_tensor, oc*IN_PLANE + (oy*STRIDE)*IN_WIDTH + (ox*STRIDE));
          end
          out_p0[((oc*OUT_HEIGHT + oy)*OUT_WIDTH + ox)*DATA_WIDTH +: DATA_WIDTH] =
            narrow(relu_shift(conv_acc + sc_acc));
        end
      end
    end
  end

  // Stage p1: output register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1 <= '0;
    end else begin
      out_p1 <= out_p0;
    end
  end

  assign output_tensor = out_p1;

endmodule

// File: tb/tb_residual_block.sv
module tb_residual_block;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_t;
  logic [71:0]  out_def;
  logic [71:0]  out_pw2;
  logic [71:0]  out_id;
  logic [71:0]  out_sh1;
  logic [31:0]  out_st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  residual_block dut (
    .clk(clk), .rst(rst), .input_tensor(in_t), .output_tensor(out_def)
  );

  residual_block #(.PROJ_WEIGHT(2)) dut_pw2 (
    .clk(clk), .rst(rst), .input_tensor(in_t), .output_tensor(out_pw2)
  );

  residual_block #(.USE_PROJECTION_SHORTCUT(0)) dut_id (
    .clk(clk), .rst(rst), .input_tensor(in_t), .output_tensor(out_id)
  );

  residual_block #(.OUT_SHIFT(1)) dut_sh1 (
    .clk(clk), .rst(rst), .input_tensor(in_t), .output_tensor(out_sh1)
  );

  residual_block #(.STRIDE(2)) dut_st2 (
    .clk(clk), .rst(rst), .input_tensor(in_t), .output_tensor(out_st2)
  );

  // Hand-computed: 2x2 sum of ones-kernel at p is 4p+10, shortcut p -> 5p+10.
  int exp_ramp[9] = '{10, 15, 20, 30, 35, 40, 50, 55, 60};
  // Shortcut weight 2: 6p+10.
  int exp_pw2[9]  = '{10, 16, 22, 34, 40, 46, 58, 64, 70};
  // 5p+10 shifted right by 1.
  int exp_sh1[9]  = '{5, 7, 10, 15, 17, 20, 25, 27, 30};
  // Stride 2 windows at p = 0, 2, 8, 10.
  int exp_st2[4]  = '{10, 20, 50, 60};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int el9(input logic [71:0] t, input int o);
    logic signed [7:0] e;
    e = $signed(t[o*8 +: 8]);
    return int'(e);
  endfunction

  function automatic int el4(input logic [31:0] t, input int o);
    logic signed [7:0] e;
    e = $signed(t[o*8 +: 8]);
    return int'(e);
  endfunction

  task automatic fill(input int v);
    for (int i = 0; i < 16; i++) in_t[i*8 +: 8] = 8'(v);
  endtask

  task automatic ramp();
    for (int i = 0; i < 16; i++) in_t[i*8 +: 8] = 8'(i);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_const(input string tag, input int exp);
    for (int o = 0; o < 9; o++) check($sformatf("%s[%0d]", tag, o), el9(out_def, o), exp);
  endtask

  task automatic check_ramp_def(input string tag);
    for (int o = 0; o < 9; o++) check($sformatf("%s[%0d]", tag, o), el9(out_def, o), exp_ramp[o]);
  endtask

  initial begin
    rst = 1'b1;
    ramp();

    // Reset held for two edges: outputs stay zero.
    step();
    check_all_const("rst_edge1", 0);
    step();
    check_all_const("rst_edge2", 0);
    for (int o = 0; o < 4; o++) check($sformatf("rst_st2[%0d]", o), el4(out_st2, o), 0);

    // Ramp after reset release: result one edge later.
    rst = 1'b0;
    step();
    check_ramp_def("ramp");
    for (int o = 0; o < 9; o++) begin
      check($sformatf("pw2[%0d]", o), el9(out_pw2, o), exp_pw2[o]);
      check($sformatf("ident[%0d]", o), el9(out_id, o), exp_ramp[o]);
      check($sformatf("shift1[%0d]", o), el9(out_sh1, o), exp_sh1[o]);
    end
    for (int o = 0; o < 4; o++) check($sformatf("stride2[%0d]", o), el4(out_st2, o), exp_st2[o]);

    // Input change between edges does not reach the output.
    fill(-1);
    #3;
    check("hold_between_edges[0]", el9(out_def, 0), 10);
    check("hold_between_edges[8]", el9(out_def, 8), 60);

    // All -1: sum = -5, ReLU gives 0.
    step();
    check_all_const("relu_neg", 0);

    // All 100: sum = 500 -> saturate to 127 or wrap to 0xF4 = -12.
    fill(100);
    step();
`ifdef RESIDUAL_BLOCK_SAT_EN
    check_all_const("big_sat", 127);
`else
    check_all_const("big_wrap", -12);
`endif

    // Mid-stream reset for one edge.
    ramp();
    step();
    check_ramp_def("ramp_pre_rst");
    rst = 1'b1;
    step();
    check_all_const("mid_rst", 0);
    rst = 1'b0;
    step();
    check_ramp_def("ramp_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
